// File: rtl/lse_simd_pkg.sv
// Shared types and widths for the log-domain SIMD multiplier (integer adder) stage.
package lse_simd_pkg;

    localparam int unsigned WORD_W   = 24;
    localparam int unsigned LANE12_W = 12;
    localparam int unsigned LANE6_W  = 6;
    localparam int unsigned SEG_N    = WORD_W / LANE6_W;

    typedef enum logic [1:0] {
        SIMD_1X24 = 2'b00,
        SIMD_2X12 = 2'b01,
        SIMD_4X6  = 2'b10,
        SIMD_RSVD = 2'b11
    } simd_mode_e;

endpackage : lse_simd_pkg

// File: rtl/lse_mult_simd_if.sv
// Operand/result bus of lse_mult_simd; lane_ovf exists only with LSE_MULT_SIMD_OVF_EN.
interface lse_mult_simd_if;
    import lse_simd_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] operand_a;
    logic [WORD_W-1:0] operand_b;
    logic [1:0]        simd_mode;
    logic              out_valid;
    logic [WORD_W-1:0] result;
`ifdef LSE_MULT_SIMD_OVF_EN
    logic [SEG_N-1:0]  lane_ovf;
`endif

    modport master (
        output in_valid, operand_a, operand_b, simd_mode,
        input  out_valid, result
`ifdef LSE_MULT_SIMD_OVF_EN
        , input lane_ovf
`endif
    );

    modport slave (
        input  in_valid, operand_a, operand_b, simd_mode,
        output out_valid, result
`ifdef LSE_MULT_SIMD_OVF_EN
        , output lane_ovf
`endif
    );

endinterface : lse_mult_simd_if

// File: rtl/lse_simd_seg_adder.sv
// Combinational 24-bit adder of four 6-bit segments; kill[k] cuts the carry from segment k into k+1.
module lse_simd_seg_adder
    import lse_simd_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [SEG_N-2:0]  kill,
    output logic [WORD_W-1:0] sum,
    output logic [SEG_N-1:0]  cout
);

    logic [LANE6_W:0] seg;
    logic             cin;
    logic [SEG_N-1:0] kill_ext;

    assign kill_ext = {1'b1, kill};

    // Ripple through the segments, masking the carry at each killed boundary.
    always_comb begin
        sum  = '0;
        cout = '0;
        seg  = '0;
        cin  = 1'b0;
        for (int k = 0; k < int'(SEG_N); k++) begin
            seg = (LANE6_W+1)'(a[k*LANE6_W +: LANE6_W])
                + (LANE6_W+1)'(b[k*LANE6_W +: LANE6_W])
                + (LANE6_W+1)'(cin);
            sum[k*LANE6_W +: LANE6_W] = seg[LANE6_W-1:0];
            cout[k] = seg[LANE6_W];
            cin     = seg[LANE6_W] & ~kill_ext[k];
        end
    end

endmodule : lse_simd_seg_adder

// File: rtl/lse_mult_simd.sv
// Log-domain multiply stage: packed 1x24 / 2x12 / 4x6 lane adds, one registered result per cycle.
// Optional per-lane carry-out port enabled by LSE_MULT_SIMD_OVF_EN.
module lse_mult_simd
    import lse_simd_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    lse_mult_simd_if.slave  bus
);

    simd_mode_e        mode;
    logic [SEG_N-2:0]  kill;
    logic [WORD_W-1:0] sum;
    logic [SEG_N-1:0]  cout;
    logic [WORD_W-1:0] result_d;
    logic [SEG_N-1:0]  ovf_d;

    logic              valid_q;
    logic [WORD_W-1:0] result_q;

    assign mode = simd_mode_e'(bus.simd_mode);

    lse_simd_seg_adder u_adder (
        .a    (bus.operand_a),
        .b    (bus.operand_b),
        .kill (kill),
        .sum  (sum),
        .cout (cout)
    );

    // Mode decode: boundary kills, lane carry-out mapping, reserved-mode zeroing.
    always_comb begin
        kill     = '1;
        result_d = sum;
        ovf_d    = '0;
        case (mode)
            SIMD_1X24: begin
                kill  = 3'b000;
                ovf_d = {3'b000, cout[3]};
            end
            SIMD_2X12: begin
                kill  = 3'b010;
                ovf_d = {2'b00, cout[3], cout[1]};
            end
            SIMD_4X6: begin
                kill  = 3'b111;
                ovf_d = cout;
            end
            default: begin
                kill     = 3'b111;
                result_d = '0;
                ovf_d    = '0;
            end
        endcase
    end

`ifdef LSE_MULT_SIMD_OVF_EN
    logic [SEG_N-1:0] ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (bus.in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.lane_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf_d;
`endif

    // Output stage: result holds across idle cycles, valid follows the input by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;

endmodule : lse_mult_simd

// File: tb/tb_lse_mult_simd.sv
// Directed + random scoreboard bench for lse_mult_simd (lane_ovf checked when LSE_MULT_SIMD_OVF_EN is set).
module tb_lse_mult_simd;
    import lse_simd_pkg::*;

    typedef struct packed {
        logic [23:0] res;
        logic [3:0]  ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    exp_t scoreboard[$];
    logic [23:0] last_res;
    logic [3:0]  last_ovf;

    lse_mult_simd_if bus();

    lse_mult_simd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: independent per-lane modular addition.
    function automatic exp_t model(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        int unsigned lw;
        int unsigned n;
        longint unsigned mask, sa, sbv, s;
        e = '0;
        if (m == 2'b11) return e;
        lw   = (m == 2'b00) ? 24 : (m == 2'b01) ? 12 : 6;
        n    = 24 / lw;
        mask = (64'd1 << lw) - 64'd1;
        for (int i = 0; i < int'(n); i++) begin
            sa  = (64'(a) >> (i * lw)) & mask;
            sbv = (64'(b) >> (i * lw)) & mask;
            s   = sa + sbv;
            e.res = e.res | 24'((s & mask) << (i * lw));
            e.ovf[i] = ((s >> lw) & 64'd1) != 64'd0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, sample 1 time unit after the next posedge.
    task automatic step(input logic v, input logic [1:0] m, input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        bus.in_valid  = v;
        bus.simd_mode = m;
        bus.operand_a = a;
        bus.operand_b = b;
        if (v) scoreboard.push_back(model(m, a, b));
        @(posedge clk);
        #1;
        check("out_valid", 24'(bus.out_valid), 24'(v));
        if (v) begin
            check("sb_depth", 24'(scoreboard.size()), 24'd1);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                last_res = e.res;
                last_ovf = e.ovf;
            end
        end
        check(v ? "result" : "result_hold", bus.result, last_res);
`ifdef LSE_MULT_SIMD_OVF_EN
        check(v ? "lane_ovf" : "lane_ovf_hold", 24'(bus.lane_ovf), 24'(last_ovf));
`endif
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        last_res = '0;
        last_ovf = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.simd_mode = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_result", bus.result, 24'h000000);
        check("rst_out_valid", 24'(bus.out_valid), 24'd0);
`ifdef LSE_MULT_SIMD_OVF_EN
        check("rst_lane_ovf", 24'(bus.lane_ovf), 24'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 2'b00, 24'h000123, 24'h000111);
        step(1'b1, 2'b00, 24'h00FFFF, 24'h000001);
        step(1'b1, 2'b00, 24'hFFFFFF, 24'h000001);
        step(1'b1, 2'b01, 24'hABCDEF, 24'h111111);
        step(1'b1, 2'b01, 24'hFFF000, 24'h001FFF);
        step(1'b1, 2'b01, 24'hFFFEEE, 24'h001234);
        step(1'b1, 2'b10, 24'h3F3F3F, 24'h010101);
        step(1'b1, 2'b10, 24'h123456, 24'h010101);
        step(1'b1, 2'b00, 24'h800000, 24'h800000);
        step(1'b1, 2'b11, 24'h123456, 24'h654321);
        step(1'b1, 2'b10, 24'hFFFFFF, 24'hFFFFFF);
        step(1'b0, 2'b00, 24'h111111, 24'h222222);
        step(1'b0, 2'b10, 24'hFFFFFF, 24'h000001);
        step(1'b1, 2'b01, 24'h7FF7FF, 24'h001001);

        // Reset asserted while a second operation is on the inputs.
        step(1'b1, 2'b00, 24'h000100, 24'h000200);
        bus.in_valid  = 1'b1;
        bus.simd_mode = 2'b00;
        bus.operand_a = 24'h0AAAAA;
        bus.operand_b = 24'h000001;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", bus.result, 24'h000000);
        check("midrst_out_valid", 24'(bus.out_valid), 24'd0);
        scoreboard.delete();
        @(posedge clk);
        #1;
        check("midrst_result_edge", bus.result, 24'h000000);
        check("midrst_valid_edge", 24'(bus.out_valid), 24'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        last_res     = '0;
        last_ovf     = '0;
        step(1'b0, 2'b00, 24'h0AAAAA, 24'h000001);
        step(1'b1, 2'b00, 24'h000005, 24'h000006);

        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 24'($urandom), 24'($urandom));
        end

        check("sb_drained", 24'(scoreboard.size()), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_lse_mult_simd
